// File: rtl/div_ctrl.sv
// div_ctrl: 32-bit radix-2 restoring divider for DIV/DIVU with a start/ready
// handshake, pipeline annul and stall request.
// Optional feature macro: DIV_ZERO_FLAG_EN adds the div_zero_o flag output.
//
// state  | meaning
// FREE   | idle, waiting for start_i
// BYZERO | divisor was zero, result forced to 0 on the next edge
// ON     | iterating, one quotient bit per cycle (cnt 0..31)
// END    | result_o valid, held until start_i drops
module div_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o,
`ifdef DIV_ZERO_FLAG_EN
  output logic        div_zero_o,
`endif
  output logic        stallreq_o
);

  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [5:0]  cnt;
  logic [64:0] work;
  logic [31:0] divisor;
  logic        sign_a;
  logic        sign_b;

  logic        go;
  logic        load_ops;
  logic        iterate;
  logic        finish;
  logic        zero_done;

  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic        trial_ge;
  logic [31:0] trial_diff;
  logic [64:0] work_nxt;
  logic [31:0] quot_raw;
  logic [31:0] rem_raw;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;

  assign go         = start_i & ~annul_i;
  assign stallreq_o = start_i & ~annul_i & ~ready_o;

  // Magnitudes of the operands; the signs are restored after the last step.
  assign abs_a = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
  assign abs_b = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

  // Working register layout: [64:33] partial remainder, [32:1] dividend bits
  // still to consume, low bits collect quotient bits. The trial compare uses
  // the full 33-bit shifted remainder so divisors above 2^31 are handled.
  assign trial_ge   = work[64:32] >= {1'b0, divisor};
  assign trial_diff = work[63:32] - divisor;
  assign work_nxt   = trial_ge ? {trial_diff, work[31:0], 1'b1}
                               : {work[63:0], 1'b0};

  assign quot_raw = work_nxt[31:0];
  assign rem_raw  = work_nxt[64:33];
  // 0x80000000 / -1 wraps back to 0x80000000 through this negation.
  assign quot_fix = (sign_a ^ sign_b) ? (~quot_raw + 32'd1) : quot_raw;
  assign rem_fix  = sign_a ? (~rem_raw + 32'd1) : rem_raw;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= FREE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and datapath strobes
  always_comb begin
    state_nxt = state;
    load_ops  = 1'b0;
    iterate   = 1'b0;
    finish    = 1'b0;
    zero_done = 1'b0;
    case (state)
      FREE: begin
        if (go) begin
          if (opdata2_i == 32'd0) begin
            state_nxt = BYZERO;
          end else begin
            state_nxt = ON;
            load_ops  = 1'b1;
          end
        end
      end
      BYZERO: begin
        if (annul_i) begin
          state_nxt = FREE;
        end else begin
          state_nxt = END;
          zero_done = 1'b1;
        end
      end
      ON: begin
        if (annul_i) begin
          state_nxt = FREE;
        end else begin
          iterate = 1'b1;
          if (cnt == 6'd31) begin
            state_nxt = END;
            finish    = 1'b1;
          end
        end
      end
      END: begin
        if (!start_i) begin
          state_nxt = FREE;
        end
      end
      default: state_nxt = FREE;
    endcase
  end

  // Operand latch, iteration, and result/ready registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt      <= 6'd0;
      work     <= 65'd0;
      divisor  <= 32'd0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      result_o <= 64'd0;
      ready_o  <= 1'b0;
    end else begin
      // counter only moves while iterating, so it is 0 in every other state
      cnt <= (iterate && !finish) ? cnt + 6'd1 : 6'd0;
      if (load_ops) begin
        work    <= {32'd0, abs_a, 1'b0};
        divisor <= abs_b;
        sign_a  <= signed_div_i & opdata1_i[31];
        sign_b  <= signed_div_i & opdata2_i[31];
      end else if (iterate) begin
        work <= work_nxt;
      end
      if (finish) begin
        result_o <= {rem_fix, quot_fix};
        ready_o  <= 1'b1;
      end else if (zero_done) begin
        result_o <= 64'd0;
        ready_o  <= 1'b1;
      end else if (state == END && !start_i) begin
        ready_o  <= 1'b0;
      end
    end
  end

`ifdef DIV_ZERO_FLAG_EN
  // Flag is high only for an END that was reached through BYZERO
  always_ff @(posedge clk) begin
    if (!rst) begin
      div_zero_o <= 1'b0;
    end else begin
      div_zero_o <= zero_done | (div_zero_o & (state_nxt == END));
    end
  end
`endif

endmodule

// File: tb/tb_div_ctrl.sv
// Scoreboard bench for div_ctrl: stimulus pushes expected results, a monitor
// pops and compares on each rising ready_o.
module tb_div_ctrl;

  logic        clk;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stallreq_o;
`ifdef DIV_ZERO_FLAG_EN
  logic        div_zero_o;
`endif

  typedef struct {
    logic [63:0] res;
    logic        dz;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  logic ready_q   = 1'b0;

  div_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
`ifdef DIV_ZERO_FLAG_EN
    .div_zero_o   (div_zero_o),
`endif
    .stallreq_o   (stallreq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  // Monitor: compare each new result against the oldest expectation
  always @(negedge clk) begin
    if (ready_o && !ready_q) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_ready", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result", result_o, e.res);
`ifdef DIV_ZERO_FLAG_EN
        chk("div_zero_flag", {63'd0, div_zero_o}, {63'd0, e.dz});
`endif
      end
    end
    ready_q = ready_o;
  end

  task automatic push_exp(input logic [63:0] res, input logic dz);
    exp_t e;
    e.res = res;
    e.dz  = dz;
    exp_q.push_back(e);
  endtask

  // One divide: start before edge N, scramble inputs after N, wait for ready.
  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp_res, input int exp_lat);
    int   cyc;
    logic stall_ok;
    push_exp(exp_res, b == 32'd0);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    stall_ok     = 1'b1;
    #1;
    if (stallreq_o !== 1'b1) stall_ok = 1'b0;
    @(negedge clk);
    opdata1_i    = $urandom;
    opdata2_i    = $urandom;
    signed_div_i = ~sgn;
    cyc = 0;
    while (!ready_o && cyc < 64) begin
      if (stallreq_o !== 1'b1) stall_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    chk("latency", 64'(cyc), 64'(exp_lat));
    chk("stall_busy", {63'd0, stall_ok}, 64'd1);
    chk("stall_done", {63'd0, stallreq_o}, 64'd0);
    repeat (2) @(negedge clk);
    chk("ready_hold", {63'd0, ready_o}, 64'd1);
    chk("result_hold", result_o, exp_res);
    start_i = 1'b0;
    @(negedge clk);
    chk("ready_clear", {63'd0, ready_o}, 64'd0);
`ifdef DIV_ZERO_FLAG_EN
    chk("div_zero_clear", {63'd0, div_zero_o}, 64'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cyc;
    logic no_ready;
    rst          = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = 32'd0;
    opdata2_i    = 32'd0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ready", {63'd0, ready_o}, 64'd0);
    chk("reset_result", result_o, 64'd0);
    chk("reset_stall", {63'd0, stallreq_o}, 64'd0);
`ifdef DIV_ZERO_FLAG_EN
    chk("reset_div_zero", {63'd0, div_zero_o}, 64'd0);
`endif
    rst = 1'b1;
    @(negedge clk);

    run_div(1'b0, 32'd100,      32'd7,          {32'h00000002, 32'h0000000E}, 32);
    run_div(1'b1, 32'hFFFFFFF9, 32'd2,          {32'hFFFFFFFF, 32'hFFFFFFFD}, 32);
    run_div(1'b1, 32'd5,        32'd0,          64'd0,                        1);
    run_div(1'b1, 32'd7,        32'hFFFFFFFE,   {32'h00000001, 32'hFFFFFFFD}, 32);

    // annul_i blocks a start in FREE
    signed_div_i = 1'b0;
    opdata1_i    = 32'd1000;
    opdata2_i    = 32'd3;
    start_i      = 1'b1;
    annul_i      = 1'b1;
    #1;
    chk("stall_annul_free", {63'd0, stallreq_o}, 64'd0);
    repeat (3) @(negedge clk);
    annul_i = 1'b0;
    @(negedge clk);
    repeat (9) @(negedge clk);
    annul_i = 1'b1;
    #1;
    chk("stall_annul_on", {63'd0, stallreq_o}, 64'd0);
    @(negedge clk);
    start_i = 1'b0;
    annul_i = 1'b0;
    no_ready = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (ready_o !== 1'b0) no_ready = 1'b0;
    end
    chk("annul_no_ready", {63'd0, no_ready}, 64'd1);
    chk("annul_result_kept", result_o, {32'h00000001, 32'hFFFFFFFD});

    run_div(1'b0, 32'd9,        32'd3,          {32'h00000000, 32'h00000003}, 32);
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF,   {32'h00000000, 32'h80000000}, 32);
    run_div(1'b0, 32'hFFFFFFF9, 32'd2,          {32'h00000001, 32'h7FFFFFFC}, 32);
    run_div(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFE,   {32'h00000001, 32'h00000001}, 32);
    run_div(1'b0, 32'hFFFFFFFF, 32'd1,          {32'h00000000, 32'hFFFFFFFF}, 32);

    // reset at edge N+20 with start held; a fresh divide follows release
    signed_div_i = 1'b0;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd7;
    start_i      = 1'b1;
    @(negedge clk);
    repeat (19) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready", {63'd0, ready_o}, 64'd0);
    chk("midrst_result", result_o, 64'd0);
`ifdef DIV_ZERO_FLAG_EN
    chk("midrst_div_zero", {63'd0, div_zero_o}, 64'd0);
`endif
    rst = 1'b1;
    push_exp({32'h00000002, 32'h0000000E}, 1'b0);
    cyc = 0;
    while (!ready_o && cyc < 64) begin
      @(negedge clk);
      cyc++;
    end
    chk("postrst_latency", 64'(cyc), 64'd33);
    start_i = 1'b0;
    @(negedge clk);
    chk("postrst_ready_clear", {63'd0, ready_o}, 64'd0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
